// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcodes, widths and the buffered entry payload.
// ALU_PARITY_EN adds a stored parity bit to each entry.
package alu_pkg;

    localparam int unsigned RESULT_W = 8;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned OP_W     = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_INV  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        alu_op_e             op;
        logic                zero;
        logic                hi_err;
`ifdef ALU_PARITY_EN
        logic                parity;
`endif
    } alu_entry_t;

    // Flags are computed once at capture so the consumer sees them with no extra logic.
    function automatic alu_entry_t make_entry(input logic [RESULT_W-1:0] result,
                                              input alu_op_e op);
        alu_entry_t e;
        e.result = result;
        e.op     = op;
        e.zero   = (result[NIBBLE_W-1:0] == NIBBLE_W'(0));
        e.hi_err = |result[RESULT_W-1:NIBBLE_W];
`ifdef ALU_PARITY_EN
        e.parity = ^result;
`endif
        return e;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// DEPTH-entry valid/ready FIFO of alu_entry_t; ready/valid derived from registered pointers only.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_valid,
    output logic       push_ready,
    input  alu_entry_t push_data,
    output logic       pop_valid,
    input  logic       pop_ready,
    output alu_entry_t pop_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    alu_entry_t    mem_q [DEPTH];
    alu_entry_t    mem_d [DEPTH];

    logic full_c, empty_c, push_c, pop_c;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign push_c  = push_valid && !full_c;
    assign pop_c   = pop_ready && !empty_c;

    assign push_ready = !full_c;
    assign pop_valid  = !empty_c;
    assign pop_data   = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Buffered, flag-annotating output stage for the 4-bit ALU logic units with an accepted-result counter.
// Build option ALU_PARITY_EN adds the out_parity port and per-entry parity storage.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = RESULT_W,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  alu_op_e           in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output alu_op_e           out_op,
    output logic              out_zero,
    output logic              out_hi_err,
`ifdef ALU_PARITY_EN
    output logic              out_parity,
`endif
    output logic [CNT_W-1:0]  acc_cnt
);

    alu_entry_t       in_entry_c;
    alu_entry_t       head_c;
    logic             push_c;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    assign in_entry_c = make_entry(RESULT_W'(in_result), in_op);
    assign push_c     = in_valid && in_ready;

    alu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (in_entry_c),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_c)
    );

    // Head entry is zeroed by the FIFO when empty, so outputs read 0 with no extra gating.
    assign out_result = DATA_W'(head_c.result);
    assign out_op     = head_c.op;
    assign out_zero   = head_c.zero;
    assign out_hi_err = head_c.hi_err;
`ifdef ALU_PARITY_EN
    assign out_parity = head_c.parity;
`endif
    assign acc_cnt    = acc_cnt_q;

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (push_c) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

endmodule
